// File: rtl/bg_pixel_fetch.sv
// Background-image prefetch stage: streams 16-bit background pixels from
// SDRAM into a small FIFO ahead of the raster and hands one pixel per active
// pixel strobe to the compositor as 4-bit B/A/R/G components. The image
// restarts at every VSync rising edge.
module bg_pixel_fetch #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 25,
    parameter int FRAME_WORDS = 307200
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vs,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic [3:0]        bg_r,
    output logic [3:0]        bg_g,
    output logic [3:0]        bg_b,
    output logic [3:0]        bg_a,
    output logic              underflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WORDS_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [WORDS_W-1:0] FRAME_C = WORDS_W'(FRAME_WORDS);

    // IDLE: nothing outstanding. WAIT: one read outstanding, its word is kept.
    // DROP: one read outstanding that belongs to the previous frame.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic               r_vs_d;
    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORDS_W-1:0] r_words;
    logic               r_rd_req;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [15:0]        r_pix;
    logic               r_underflow;

    logic               w_frame_start;
    logic               w_consume;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   w_count_base;
    logic [ADDR_W-1:0]  w_addr_base;
    logic [WORDS_W-1:0] w_words_base;
    logic               w_free;
    logic               w_issue;

    // FIFO push/pop decisions, occupancy and frame-restart base values.
    // A frame start overrides everything: the FIFO ends empty and any word
    // arriving in that cycle is not stored.
    always_comb begin
        w_frame_start = vs & ~r_vs_d;
        w_consume     = ce_pix & ~hblank & ~vblank & enable;
        w_fifo_empty  = (r_count == {CNT_W{1'b0}});
        w_push        = rd_valid & (r_state == FETCH_WAIT) & ~w_frame_start;
        w_pop         = w_consume & ~w_fifo_empty & ~w_frame_start;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
        if (w_frame_start) begin
            w_count_base = {CNT_W{1'b0}};
            w_addr_base  = {ADDR_W{1'b0}};
            w_words_base = {WORDS_W{1'b0}};
        end else begin
            w_count_base = w_count_next;
            w_addr_base  = r_addr;
            w_words_base = r_words;
        end
    end

    // Request decision and next fetch state. The returning rd_valid frees the
    // slot in the same cycle, so the next request follows it immediately;
    // the occupancy test uses the post-push count so the FIFO never overflows.
    always_comb begin
        w_free  = (r_state == FETCH_IDLE) | rd_valid;
        w_issue = enable & w_free & (w_count_base < DEPTH_C) & (w_words_base < FRAME_C);
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: begin
                if (w_issue) w_state_next = FETCH_WAIT;
                else         w_state_next = FETCH_IDLE;
            end
            FETCH_WAIT: begin
                if (rd_valid) begin
                    if (w_issue) w_state_next = FETCH_WAIT;
                    else         w_state_next = FETCH_IDLE;
                end else if (w_frame_start) begin
                    w_state_next = FETCH_DROP;
                end else begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_DROP: begin
                if (rd_valid) begin
                    if (w_issue) w_state_next = FETCH_WAIT;
                    else         w_state_next = FETCH_IDLE;
                end else begin
                    w_state_next = FETCH_DROP;
                end
            end
            default: w_state_next = FETCH_IDLE;
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk_50) begin
        if (reset) r_state <= FETCH_IDLE;
        else       r_state <= w_state_next;
    end

    // Delayed vsync for rising-edge detection.
    always_ff @(posedge clk_50) begin
        if (reset) r_vs_d <= 1'b0;
        else       r_vs_d <= vs;
    end

    // Registered read request, frame address and per-frame word counter.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_rd_req  <= 1'b0;
            r_rd_addr <= {ADDR_W{1'b0}};
            r_addr    <= {ADDR_W{1'b0}};
            r_words   <= {WORDS_W{1'b0}};
        end else begin
            r_rd_req <= w_issue;
            if (w_issue) begin
                r_rd_addr <= w_addr_base;
                r_addr    <= w_addr_base + ADDR_W'(2);
                r_words   <= w_words_base + WORDS_W'(1);
            end else begin
                r_addr    <= w_addr_base;
                r_words   <= w_words_base;
            end
        end
    end

    // FIFO pointers and occupancy; flushed at frame start.
    always_ff @(posedge clk_50) begin
        if (reset || w_frame_start) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk_50) begin
        if (w_push) r_mem[r_wr_ptr] <= rd_data;
    end

    // Output pixel register: pop on an active strobe, black when starved,
    // blanked or disabled, otherwise hold between strobes.
    always_ff @(posedge clk_50) begin
        if (reset || !enable) begin
            r_pix <= 16'h0000;
        end else if (w_consume) begin
            if (w_pop) r_pix <= r_mem[r_rd_ptr];
            else       r_pix <= 16'h0000;
        end else if (ce_pix) begin
            r_pix <= 16'h0000;
        end
    end

    // Sticky per-frame underflow flag.
    always_ff @(posedge clk_50) begin
        if (reset || w_frame_start)            r_underflow <= 1'b0;
        else if (w_consume && w_fifo_empty)    r_underflow <= 1'b1;
    end

    assign rd_req    = r_rd_req;
    assign rd_addr   = r_rd_addr;
    assign {bg_b, bg_a, bg_r, bg_g} = r_pix;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Directed bench for bg_pixel_fetch: a default instance (16-deep FIFO) and a
// small-frame instance (4-deep FIFO, 8 words per frame) share the video
// timing inputs; each has its own SDRAM responder with fixed latency.
module tb_bg_pixel_fetch;

    logic        clk_50 = 1'b0;
    logic        reset, enable, ce_pix, hblank, vblank, vs;
    logic        rd_req, rd_valid, rd_req2, rd_valid2, underflow, underflow2;
    logic [24:0] rd_addr, rd_addr2;
    logic [15:0] rd_data, rd_data2;
    logic [3:0]  bg_r, bg_g, bg_b, bg_a, bg_r2, bg_g2, bg_b2, bg_a2;

    int tests = 0;
    int fails = 0;

    // SDRAM responder / scoreboard state
    int          lat = 3;
    int          resp_cnt = 0, resp_cnt2 = 0;
    logic [24:0] resp_addr, resp_addr2;
    int          n_req = 0, n_req2 = 0;
    logic [24:0] exp_addr = '0, exp_addr2 = '0;
    logic [24:0] last_addr = 25'h1FFFFFF, last_addr2 = 25'h1FFFFFF;
    logic [15:0] q[$];
    logic        push_pend = 1'b0, fs_pend = 1'b0, drop = 1'b0, uf_model = 1'b0;
    logic [15:0] push_word;

    bg_pixel_fetch dut (
        .clk_50(clk_50), .reset(reset), .enable(enable), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vs(vs), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a), .underflow(underflow)
    );

    bg_pixel_fetch #(.FIFO_DEPTH(4), .ADDR_W(25), .FRAME_WORDS(8)) dut2 (
        .clk_50(clk_50), .reset(reset), .enable(enable), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vs(vs), .rd_req(rd_req2),
        .rd_addr(rd_addr2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .bg_r(bg_r2), .bg_g(bg_g2), .bg_b(bg_b2), .bg_a(bg_a2), .underflow(underflow2)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word_of(input logic [24:0] a);
        logic [15:0] idx;
        idx = 16'(a >> 1);
        return 16'h1234 + idx * 16'h4444;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample just after the edge, update the models, drive responses.
    task automatic cyc();
        @(posedge clk_50);
        #1;
        if (fs_pend) begin
            q.delete();
            drop     = (resp_cnt != 0);
            uf_model = 1'b0;
            fs_pend  = 1'b0;
        end else if (push_pend) begin
            q.push_back(push_word);
        end
        push_pend = 1'b0;
        rd_valid  = 1'b0;
        rd_valid2 = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                rd_valid = 1'b1;
                rd_data  = word_of(resp_addr);
                if (drop) drop = 1'b0;
                else begin push_pend = 1'b1; push_word = rd_data; end
            end
        end
        if (resp_cnt2 > 0) begin
            resp_cnt2--;
            if (resp_cnt2 == 0) begin rd_valid2 = 1'b1; rd_data2 = word_of(resp_addr2); end
        end
        if (rd_req === 1'b1) begin
            chk("req_single_outstanding", resp_cnt, 0);
            chk("req_addr", rd_addr, exp_addr);
            resp_cnt = lat; resp_addr = rd_addr; last_addr = rd_addr;
            exp_addr = exp_addr + 25'd2; n_req++;
        end
        if (rd_req2 === 1'b1) begin
            chk("req2_single_outstanding", resp_cnt2, 0);
            chk("req2_addr", rd_addr2, exp_addr2);
            resp_cnt2 = lat; resp_addr2 = rd_addr2; last_addr2 = rd_addr2;
            exp_addr2 = exp_addr2 + 25'd2; n_req2++;
        end
    endtask

    // One pixel period (strobe cycle + idle cycle); checks the strobed pixel.
    task automatic pixel(input logic act);
        logic [15:0] expv;
        expv = 16'h0000;
        if (act && enable) begin
            if (q.size() > 0) expv = q.pop_front();
            else              uf_model = 1'b1;
        end
        ce_pix = 1'b1; hblank = ~act;
        cyc();
        chk("pixel", {bg_b, bg_a, bg_r, bg_g}, expv);
        chk("underflow", underflow, uf_model);
        ce_pix = 1'b0; hblank = 1'b1;
        cyc();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; fs_pend = 1'b1; exp_addr = '0; exp_addr2 = '0;
        cyc();
        vs = 1'b0;
    endtask

    initial begin
        int nr;
        logic [24:0] ea;
        reset = 1'b1; enable = 1'b1; ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b0;
        vs = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_valid2 = 1'b0; rd_data2 = '0;
        for (int i = 0; i < 5; i++) cyc();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_pixel", {bg_b, bg_a, bg_r, bg_g}, 0);
        chk("rst_fifo_count", dut.r_count, 0);

        // Fill: latency 3, no active video -> 16 requests at 0..30.
        reset = 1'b0;
        cyc();
        chk("first_req", rd_req, 1);
        chk("first_addr", rd_addr, 0);
        for (int i = 0; i < 99; i++) cyc();
        chk("fill_req_count", n_req, 16);
        chk("fill_last_addr", last_addr, 30);
        chk("fill_fifo_count", dut.r_count, 16);
        chk("fill_rd_req_idle", rd_req, 0);
        chk("small_fill_req_count", n_req2, 4);

        // Two active pixels: 0x1234 then 0x5678, refill at 32.
        pixel(1'b1);
        chk("pix0_b", bg_b, 4'h1); chk("pix0_a", bg_a, 4'h2);
        chk("pix0_r", bg_r, 4'h3); chk("pix0_g", bg_g, 4'h4);
        pixel(1'b1);
        chk("pix1_b", bg_b, 4'h5); chk("pix1_a", bg_a, 4'h6);
        chk("pix1_r", bg_r, 4'h7); chk("pix1_g", bg_g, 4'h8);
        chk("refill_addr", last_addr, 32);
        cyc();
        chk("pixel_hold", {bg_b, bg_a, bg_r, bg_g}, 16'h5678);
        pixel(1'b0);
        chk("blank_black", {bg_b, bg_a, bg_r, bg_g}, 16'h0000);

        // Latency 10, continuous active video until the 0x40 read is outstanding.
        lat = 10;
        for (int i = 0; i < 300 && last_addr != 25'h40; i++) pixel(1'b1);
        chk("reach_addr_40", last_addr, 25'h40);
        chk("starved_underflow", underflow, 1);
        chk("small_frame_req_count", n_req2, 8);
        chk("small_frame_last_addr", last_addr2, 14);
        chk("small_frame_underflow", underflow2, 1);
        chk("small_frame_no_req", rd_req2, 0);

        // vs rise with 0x40 outstanding: word dropped, restart at address 0.
        nr = n_req;
        vs_pulse();
        chk("vs_clears_underflow", underflow, 0);
        chk("vs_flush", dut.r_count, 0);
        for (int i = 0; i < 30 && n_req == nr; i++) cyc();
        chk("restart_req_count", n_req, nr + 1);
        chk("restart_addr", last_addr, 0);
        chk("discard_fifo_empty", dut.r_count, 0);
        chk("small_frame_restart", (n_req2 > 8) ? 1 : 0, 1);
        pixel(1'b1);
        chk("empty_pixel_black", {bg_b, bg_a, bg_r, bg_g}, 16'h0000);
        chk("empty_underflow", underflow, 1);
        for (int i = 0; i < 12; i++) cyc();
        pixel(1'b1);
        chk("restart_pixel", {bg_b, bg_a, bg_r, bg_g}, 16'h1234);
        chk("underflow_sticky", underflow, 1);
        vs_pulse();
        chk("vs2_clears_underflow", underflow, 0);

        // enable=0: no requests, black pixels; resume at current address.
        for (int i = 0; i < 30; i++) cyc();
        enable = 1'b0;
        cyc();
        nr = n_req;
        pixel(1'b1);
        chk("disabled_black", {bg_b, bg_a, bg_r, bg_g}, 16'h0000);
        pixel(1'b0);
        for (int i = 0; i < 30; i++) cyc();
        chk("disabled_no_req", n_req, nr);
        chk("disabled_rd_req", rd_req, 0);
        ea = exp_addr;
        enable = 1'b1;
        for (int i = 0; i < 20 && n_req == nr; i++) cyc();
        chk("resume_req_count", n_req, nr + 1);
        chk("resume_addr", last_addr, ea);
        for (int i = 0; i < 20; i++) cyc();
        for (int i = 0; i < 4; i++) pixel(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
